cpu_run_ctrl: RTL and testbench

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

---
 rtl/cpu_run_ctrl.sv | 98 +++++++++
 tb/tb_cpu_run_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: sequences reset, run and halt of up to eight CPU
// channels under a run-cycle budget, reporting completion or timeout.
module cpu_run_ctrl #(
    parameter int NUM_CPUS       = 1,
    parameter int RESET_CYCLES   = 1,
    parameter int MAX_CYCLES     = 20,
    parameter int CNT_W          = 16,
    parameter int FREEZE_ON_HALT = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [NUM_CPUS-1:0] halt_in,
    output logic [NUM_CPUS-1:0] cpu_reset,
    output logic [CNT_W-1:0]    run_cycles,
    output logic [NUM_CPUS-1:0] halted_mask,
    output logic                busy,
    output logic                done,
    output logic                timeout
);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_RESET_HOLD = 2'd1;
    localparam logic [1:0] S_RUN        = 2'd2;
    localparam logic [1:0] S_DONE       = 2'd3;

    localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HW-1:0]    HOLD_LAST = HW'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] BUDGET    = CNT_W'(MAX_CYCLES);

    logic [1:0]          state;
    logic [HW-1:0]       hold_cnt;
    logic [NUM_CPUS-1:0] mask_next;
    logic [NUM_CPUS-1:0] run_rst;
    logic [CNT_W-1:0]    cycles_next;
    logic                all_halted;
    logic                budget_hit;

    // Next-cycle run bookkeeping; halt takes priority over the budget.
    always_comb begin
        mask_next   = halted_mask | halt_in;
        all_halted  = &mask_next;
        cycles_next = (run_cycles >= BUDGET) ? run_cycles
                                             : run_cycles + CNT_W'(1);
        budget_hit  = (cycles_next >= BUDGET);
        run_rst     = (FREEZE_ON_HALT != 0) ? mask_next : '0;
    end

    // Run-control FSM with all outputs registered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            hold_cnt    <= '0;
            cpu_reset   <= '1;
            run_cycles  <= '0;
            halted_mask <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_RESET_HOLD;
                        hold_cnt    <= '0;
                        cpu_reset   <= '1;
                        run_cycles  <= '0;
                        halted_mask <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        timeout     <= 1'b0;
                    end
                end
                S_RESET_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state     <= S_RUN;
                        cpu_reset <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                S_RUN: begin
                    run_cycles  <= cycles_next;
                    halted_mask <= mask_next;
                    cpu_reset   <= run_rst;
                    if (all_halted || budget_hit) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        timeout   <= !all_halted;
                        cpu_reset <= '1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: table-driven runs with a completion scoreboard,
// plus reset and mid-run abort sequences.
module tb_cpu_run_ctrl;

    localparam int NC = 2;
    localparam int RC = 4;
    localparam int MC = 12;
    localparam int CW = 16;
    localparam logic [NC-1:0] ALL = '1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [NC-1:0] halt_in = '0;
    logic [NC-1:0] cpu_reset;
    logic [CW-1:0] run_cycles;
    logic [NC-1:0] halted_mask;
    logic          busy;
    logic          done;
    logic          timeout;

    int checks = 0;
    int errors = 0;

    // Free-running 10-unit clock.
    always #5 clock = ~clock;

    cpu_run_ctrl #(
        .NUM_CPUS      (NC),
        .RESET_CYCLES  (RC),
        .MAX_CYCLES    (MC),
        .CNT_W         (CW),
        .FREEZE_ON_HALT(1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .halt_in    (halt_in),
        .cpu_reset  (cpu_reset),
        .run_cycles (run_cycles),
        .halted_mask(halted_mask),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout)
    );

    typedef struct {
        int            h0;
        int            h1;
        int            start_k;
        bit            noise;
        int            rc;
        bit            to;
        logic [NC-1:0] mask;
    } vec_t;

    typedef struct {
        int            rc;
        bit            to;
        logic [NC-1:0] mask;
        int            done_n;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(ALL));
        chk({tag, "_run_cycles"}, 32'(run_cycles), 0);
        chk({tag, "_mask"}, 32'(halted_mask), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_timeout"}, 32'(timeout), 0);
    endtask

    // One run: halt pulses at RUN cycles h0/h1 (0 = never).
    task automatic run_vec(input vec_t v);
        exp_t          e;
        exp_t          got;
        bit            seen;
        int            k;
        logic [NC-1:0] exp_rst;
        seen     = 1'b0;
        e.rc     = v.rc;
        e.to     = v.to;
        e.mask   = v.mask;
        e.done_n = RC + v.rc + 1;
        @(negedge clock);
        start = 1'b1;
        sb.push_back(e);
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(negedge clock);
            start   = 1'b0;
            halt_in = '0;
            if (done) begin
                seen = 1'b1;
                got  = sb.pop_front();
                chk("done_time", 32'(n), 32'(got.done_n));
                chk("final_run_cycles", 32'(run_cycles), 32'(got.rc));
                chk("final_timeout", 32'(timeout), 32'(got.to));
                chk("final_mask", 32'(halted_mask), 32'(got.mask));
                chk("done_busy", 32'(busy), 0);
                chk("done_cpu_reset", 32'(cpu_reset), 32'(ALL));
            end else if (n <= RC) begin
                chk("hold_cpu_reset", 32'(cpu_reset), 32'(ALL));
                chk("hold_busy", 32'(busy), 1);
                if (n == 1) begin
                    chk("clr_done", 32'(done), 0);
                    chk("clr_timeout", 32'(timeout), 0);
                    chk("clr_run_cycles", 32'(run_cycles), 0);
                    chk("clr_mask", 32'(halted_mask), 0);
                end
                if (v.noise) begin
                    start   = 1'b1;
                    halt_in = ALL;
                end
            end else begin
                k = n - RC;
                exp_rst[0] = (v.h0 != 0) && (v.h0 < k);
                exp_rst[1] = (v.h1 != 0) && (v.h1 < k);
                chk("run_count", 32'(run_cycles), 32'(k - 1));
                chk("run_cpu_reset", 32'(cpu_reset), 32'(exp_rst));
                chk("run_busy", 32'(busy), 1);
                halt_in[0] = (k == v.h0);
                halt_in[1] = (k == v.h1);
                if (k == v.start_k) start = 1'b1;
            end
        end
        start   = 1'b0;
        halt_in = '0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_wait got none expected done by cycle 40");
            if (sb.size() > 0) void'(sb.pop_front());
        end
    endtask

    initial begin
        vecs[0] = '{0, 0, 0, 1'b0, 12, 1'b1, 2'b00};
        vecs[1] = '{5, 9, 0, 1'b0, 9, 1'b0, 2'b11};
        vecs[2] = '{9, 5, 0, 1'b0, 9, 1'b0, 2'b11};
        vecs[3] = '{3, 3, 0, 1'b0, 3, 1'b0, 2'b11};
        vecs[4] = '{1, 12, 0, 1'b0, 12, 1'b0, 2'b11};
        vecs[5] = '{4, 0, 0, 1'b0, 12, 1'b1, 2'b01};
        vecs[6] = '{1, 1, 0, 1'b0, 1, 1'b0, 2'b11};
        vecs[7] = '{0, 7, 0, 1'b0, 12, 1'b1, 2'b10};
        vecs[8] = '{6, 6, 2, 1'b1, 6, 1'b0, 2'b11};

        #1 reset = 1'b0;
        #1 chk_reset_vals("por");
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        chk("start_in_reset_busy", 32'(busy), 0);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        chk_reset_vals("idle");

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (RC + 3) @(negedge clock);
        chk("mid_busy", 32'(busy), 1);
        chk("mid_run_cycles", 32'(run_cycles), 3);
        chk("mid_cpu_reset", 32'(cpu_reset), 0);
        #2 reset = 1'b0;
        #1 chk_reset_vals("abort");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("post_abort_busy", 32'(busy), 0);
        run_vec(vecs[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
